// File: rtl/raster_coord_gen.sv
// rtl/raster_coord_gen.sv - raster timing and pixel-coordinate generator
module raster_coord_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [10:0] gr_x,
  output logic [9:0]  gr_y,
  output logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All window edges are strictly below the totals, so they fit the coordinate widths.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        line_end;
  logic        frame_end;
  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;
  logic        scan_nxt;

  // Next scan position and state; outputs below are decoded from these so they line up with gr_x/gr_y.
  always_comb begin
    line_end  = (gr_x == H_LAST);
    frame_end = line_end && (gr_y == V_LAST);
    x_nxt     = line_end ? 11'd0 : gr_x + 11'd1;
    y_nxt     = gr_y;
    if (frame_end) begin
      y_nxt = 10'd0;
    end else if (line_end) begin
      y_nxt = gr_y + 10'd1;
    end

    state_nxt = state;
    case (state)
      IDLE: begin
        if (run) state_nxt = RUN;
      end
      RUN: begin
        if (!run) state_nxt = frame_end ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (frame_end)  state_nxt = IDLE;
        else if (run)   state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase

    // Leaving IDLE starts at the origin; entering IDLE parks there.
    if (state == IDLE || state_nxt == IDLE) begin
      x_nxt = 11'd0;
      y_nxt = 10'd0;
    end
    scan_nxt = (state_nxt != IDLE);
  end

  // Scan state machine with every output registered from the next position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gr_x        <= 11'd0;
      gr_y        <= 10'd0;
      en          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      state       <= state_nxt;
      busy        <= scan_nxt;
      gr_x        <= x_nxt;
      gr_y        <= y_nxt;
      en          <= scan_nxt && (x_nxt < H_ACT) && (y_nxt < V_ACT);
      hsync       <= (scan_nxt && (x_nxt >= HS_BEG) && (x_nxt < HS_END)) ? HS_POL : ~HS_POL;
      vsync       <= (scan_nxt && (y_nxt >= VS_BEG) && (y_nxt < VS_END)) ? VS_POL : ~VS_POL;
      line_start  <= scan_nxt && (x_nxt == 11'd0);
      frame_start <= scan_nxt && (x_nxt == 11'd0) && (y_nxt == 10'd0);
      if (state != IDLE && frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_raster_coord_gen.sv
// tb/tb_raster_coord_gen.sv - self-checking bench for raster_coord_gen
module tb_raster_coord_gen;

  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [10:0] gr_x;
  logic [9:0]  gr_y;
  logic        en, hsync, vsync, line_start, frame_start, busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  raster_coord_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .gr_x(gr_x), .gr_y(gr_y), .en(en), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: linear position within the frame plus the previous run sample.
  bit m_scan;
  bit m_prev;
  int m_pos;
  int m_frames;

  int en_cnt, ls_cnt, fs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan   = 1'b0;
    m_prev   = 1'b0;
    m_pos    = 0;
    m_frames = 0;
  endtask

  task automatic model_update(input logic r);
    if (!m_scan) begin
      if (r) begin
        m_scan = 1'b1;
        m_pos  = 0;
      end
    end else if (m_pos == FRAME - 1) begin
      m_frames = (m_frames + 1) % 65536;
      m_pos    = 0;
      if (!r || !m_prev) m_scan = 1'b0;
    end else begin
      m_pos++;
    end
    m_prev = r;
  endtask

  task automatic check_outputs();
    int ex, ey;
    bit xen, xhs, xvs, xls, xfs;
    ex  = m_scan ? m_pos % HT : 0;
    ey  = m_scan ? m_pos / HT : 0;
    xen = m_scan && ex < HA && ey < VA;
    xhs = !(m_scan && ex >= HA + HF && ex < HA + HF + HS);
    xvs = !(m_scan && ey >= VA + VF && ey < VA + VF + VS);
    xls = m_scan && ex == 0;
    xfs = m_scan && m_pos == 0;
    chk("gr_x", gr_x, ex);
    chk("gr_y", gr_y, ey);
    chk("en", en, xen);
    chk("hsync", hsync, xhs);
    chk("vsync", vsync, xvs);
    chk("line_start", line_start, xls);
    chk("frame_start", frame_start, xfs);
    chk("busy", busy, m_scan);
    chk("frame_cnt", frame_cnt, m_frames);
    if (en) en_cnt++;
    if (line_start) ls_cnt++;
    if (frame_start) fs_cnt++;
  endtask

  task automatic step(input logic r);
    run = r;
    @(posedge clk);
    model_update(r);
    #2;
    check_outputs();
  endtask

  // Step with run high until the model reaches a target position; bounded.
  task automatic run_to(input int pos, input string tag);
    int n;
    n = 0;
    while (!(m_scan && m_pos == pos) && n < 4 * FRAME) begin
      step(1'b1);
      n++;
    end
    chk({tag, "_reached"}, (m_scan && m_pos == pos), 1);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_outputs();
    reset = 1'b0;

    // Idle with run low: everything stays at reset values.
    repeat (20) step(1'b0);
    chk("idle_hsync", hsync, 1);
    chk("idle_vsync", vsync, 1);

    // Two back-to-back frames.
    en_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    repeat (2 * FRAME) step(1'b1);
    chk("en_per_2frames", en_cnt, 2 * HA * VA);
    chk("ls_per_2frames", ls_cnt, 2 * VT);
    chk("fs_per_2frames", fs_cnt, 2);
    chk("cnt_after_2", frame_cnt, 1);

    // Third frame: drop run at gr_y=2, frame drains to completion then idles.
    run_to(2 * HT, "drop_point");
    fs_cnt = 0;
    repeat (FRAME + 20) step(1'b0);
    chk("drain_busy", busy, 0);
    chk("drain_cnt", frame_cnt, 3);
    chk("drain_no_fs", fs_cnt, 0);

    // One-clock run glitch at (3,1) leaves the scan untouched.
    run_to(HT + 3, "glitch_point");
    step(1'b0);
    fs_cnt = 0;
    repeat (2 * FRAME) step(1'b1);
    chk("glitch_fs", fs_cnt, 2);

    // Asynchronous reset at (5,3), then restart one clock after release.
    run_to(3 * HT + 5, "reset_point");
    #1 reset = 1'b1;
    #1;
    chk("areset_x", gr_x, 0);
    chk("areset_y", gr_y, 0);
    chk("areset_cnt", frame_cnt, 0);
    chk("areset_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    step(1'b1);
    chk("restart_fs", frame_start, 1);

    // Randomized run patterns: hold each level for a random length.
    for (int k = 0; k < 150; k++) begin
      logic lvl;
      int   len;
      lvl = ($urandom_range(0, 9) < 7);
      len = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 60);
      for (int j = 0; j < len; j++) step(lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raster_coord_gen.md
# raster_coord_gen

Raster timing and pixel-coordinate generator that drives the `gr_x`/`gr_y`/`en` inputs of the window-overlay drawing blocks and the sync outputs of the video port. It scans a programmable frame of `H_TOTAL × V_TOTAL` pixel clocks. Start and stop are controlled by `run`, and a stop request always lets the current frame finish. Every overlay block sharing these coordinates sees identical, cycle-aligned position and active-video flags.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync asserted level
- `VS_POL`, 0, vsync asserted level
- Derived values: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` must be ≤ 2048, and `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP` must be ≤ 1024. Every parameter is ≥ 1.

Ports:
- `clk`  in  1  pixel clock; single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `run`  in  1  scan request; level-sensitive
- `gr_x`  out  11  current horizontal position, 0..H_TOTAL-1
- `gr_y`  out  10  current vertical position, 0..V_TOTAL-1
- `en`  out  1  active video: `gr_x < H_ACTIVE` and `gr_y < V_ACTIVE` while scanning
- `hsync`  out  1  horizontal sync, polarity set by HS_POL
- `vsync`  out  1  vertical sync, polarity set by VS_POL
- `line_start`  out  1  one-clock pulse when `gr_x == 0` while scanning
- `frame_start`  out  1  one-clock pulse when `gr_x == 0` and `gr_y == 0` while scanning
- `busy`  out  1  state is not IDLE
- `frame_cnt`  out  16  number of completed frames; wraps

## Operation
- All outputs are registers. Within any one cycle, `en`, the syncs and the pulses all describe the `gr_x`/`gr_y` value presented in that same cycle.
- States and transitions:
  - IDLE: counters are held at (0,0); `en`, `line_start` and `frame_start` are 0; syncs are inactive.
  - IDLE → RUN on the edge that samples `run=1`. The next cycle presents (0,0) with `frame_start=1` and `line_start=1`.
  - RUN: the scan advances every clock.
  - RUN → DRAIN on an edge that samples `run=0`. Scanning continues unchanged.
  - DRAIN → RUN if `run=1` is sampled before the frame ends. The scan is not disturbed.
- Scan arithmetic:
  - `gr_x` increments by 1 each clock.
  - When `gr_x == H_TOTAL-1`: `gr_x` goes to 0 and `gr_y` increments.
  - When `gr_y == V_TOTAL-1` and `gr_x == H_TOTAL-1` (end of frame): `gr_y` goes to 0 and `frame_cnt` increments modulo 2^16.
- End of frame while in DRAIN, or while `run=0` is sampled in RUN:
  - `frame_cnt` still increments.
  - Next state is IDLE with counters at (0,0).
  - No `frame_start` pulse is issued.
- Sync windows (while scanning):
  - `hsync` is asserted for `H_ACTIVE+H_FP ≤ gr_x < H_ACTIVE+H_FP+H_SYNC`.
  - `vsync` is asserted for `V_ACTIVE+V_FP ≤ gr_y < V_ACTIVE+V_FP+V_SYNC`. It is line-aligned and changes only with `gr_x == 0`.
- Reset mid-frame: the scan is abandoned immediately and nothing is drained.

## Timing
- Reset values:
  - state IDLE
  - `gr_x` = 0, `gr_y` = 0
  - `en` = 0, `line_start` = 0, `frame_start` = 0, `busy` = 0
  - `hsync` = ~HS_POL, `vsync` = ~VS_POL
  - `frame_cnt` = 0
- Start latency: 1 clock from `run` being sampled high to the first (0,0) cycle with `en=1`.
- Output rates:
  - `en` is high for exactly `H_ACTIVE × V_ACTIVE` cycles per frame.
  - `line_start` pulses exactly `V_TOTAL` times per frame.
  - `frame_start` pulses once per frame.
- `busy` deasserts in the same cycle that the counters return to (0,0) in IDLE.
- Back-to-back frames in RUN have no gap: the (H_TOTAL-1, V_TOTAL-1) cycle is followed directly by (0,0).
- A `run` glitch (low for one clock, then high again) within a frame has no visible effect.

## Test plan
Small-frame parameters: H 8/1/2/1 (H_TOTAL 12), V 4/1/1/1 (V_TOTAL 7), HS_POL=VS_POL=0.

- Reset, then hold `run=0` for 20 clocks → all outputs stay at their reset values, `busy=0`, `hsync=vsync=1`.
- `run=1` held for 2 frames → 84 cycles/frame; `en` count is 32 per frame; `hsync=0` only at `gr_x` 9..10; `vsync=0` only on `gr_y`=5; `frame_start` pulses at cycles 1 and 85; `frame_cnt` reads 1 after the first frame.
- `run` dropped at `gr_y=2` in frame 0 → scanning continues to (11,6); then IDLE, `frame_cnt=1`, `busy=0`, no further `frame_start`.
- `run` low for 1 clock at (3,1), then high again → no change to scan continuity; next frame starts with no gap.
- `reset` asserted at (5,3) → `gr_x`, `gr_y`, `frame_cnt` go to 0 and `busy=0` asynchronously; with `run` still high, the scan restarts 1 clock after release.
- Force `frame_cnt` to 0xFFFF via 65536 frames, or with shortened parameters → it wraps to 0x0000 at the end of the next frame.
